// File: rtl/gold_noc_pkg.sv
// rtl/gold_noc_pkg.sv - shared constants for the gold_mesh NoC
// Purpose: packet geometry, packet field positions and NIC register addresses
// shared by the NoC blocks.
package gold_noc_pkg;

  localparam int PACKET_SIZE = 64;

  // Packet fields; the NIC itself only interprets the VC bit.
  localparam int VC_BIT   = 63;
  localparam int HOP_MSB  = 55;
  localparam int HOP_LSB  = 48;
  localparam int ADDR_MSB = 47;
  localparam int ADDR_LSB = 32;

  // NIC register map
  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/gold_nic.sv
// rtl/gold_nic.sv - PE-side network interface for a gold_router local port
// Purpose: single-entry input and output packet buffers between a processing
// element (4-register memory-mapped port) and the router local port.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   addr, d_in, d_out register select, write data, combinational read data
//   nicEn, nicWrEn    register access enable, 1 = write / 0 = read
//   net_si/ri/di      router -> NIC packet valid, NIC ready, packet
//   net_so/ro/do      NIC -> router packet valid, router ready, packet
//   net_polarity      mesh polarity; a packet leaves only when it matches VC
module gold_nic
  import gold_noc_pkg::*;
#(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_polarity
);

  logic [PACKET_SIZE-1:0] r_in_buf;
  logic                   r_in_full;
  logic [PACKET_SIZE-1:0] r_out_buf;
  logic                   r_out_full;

  logic w_rd;
  logic w_wr;
  logic w_accept;
  logic w_rd_in;
  logic w_wr_out;
  logic w_send;

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn & nicWrEn;

  // Outputs are forced quiet while reset is asserted, since the buffers
  // may still hold old contents until the reset edge.
  assign net_ri   = ~r_in_full & ~reset;
  assign w_accept = net_si & net_ri;
  assign w_rd_in  = w_rd & (addr == ADDR_IN_BUF);

  assign w_send   = r_out_full & net_ro & (net_polarity == r_out_buf[VC_BIT]) & ~reset;
  // A write while the buffer is full (including the cycle of a send) is lost.
  assign w_wr_out = w_wr & (addr == ADDR_OUT_BUF) & ~r_out_full;

  assign net_so = w_send;
  assign net_do = reset ? '0 : r_out_buf;

  always_comb begin
    d_out = '0;
    if (w_rd && !reset) begin
      case (addr)
        ADDR_IN_BUF:   d_out = r_in_buf;
        ADDR_IN_STAT:  d_out = {{(PACKET_SIZE-1){1'b0}}, r_in_full};
        ADDR_OUT_BUF:  d_out = r_out_buf;
        ADDR_OUT_STAT: d_out = {{(PACKET_SIZE-1){1'b0}}, r_out_full};
        default:       d_out = '0;
      endcase
    end
  end

  // Input channel: accept only happens when empty, so it never races a
  // consuming read (which is a no-op on an empty buffer).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_accept) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd_in) begin
      r_in_full <= 1'b0;
    end
  end

  // Output channel: load only when empty, send only when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_wr_out) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end else if (w_send) begin
      r_out_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gold_nic.sv
// tb/tb_gold_nic.sv - directed self-checking bench for gold_nic
module tb_gold_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int n_assert = 0;
  int n_fail   = 0;

  gold_nic #(.PACKET_SIZE(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up a combinational register read and let it settle (no edge).
  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00;
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

    repeat (3) tick();
    chk("rst_ri", {63'd0, net_ri}, 64'd0);
    chk("rst_so", {63'd0, net_so}, 64'd0);
    chk("rst_do", net_do, 64'd0);
    rd(2'b01);
    chk("rst_dout", d_out, 64'd0);
    idle();

    reset = 1'b0; #1;
    chk("post_rst_ri", {63'd0, net_ri}, 64'd1);
    chk("post_rst_so", {63'd0, net_so}, 64'd0);
    rd(2'b01); chk("post_rst_in_stat", d_out, 64'd0);
    rd(2'b11); chk("post_rst_out_stat", d_out, 64'd0);
    idle();

    // Router delivers a packet
    net_si = 1'b1; net_di = 64'h0000_0000_DEAD_BEEF;
    tick();
    net_si = 1'b0; net_di = '0; #1;
    chk("in_full_ri", {63'd0, net_ri}, 64'd0);
    rd(2'b01); chk("in_stat_full", d_out, 64'd1);
    idle();

    // Second packet while full is ignored
    net_si = 1'b1; net_di = 64'h1;
    tick();
    net_si = 1'b0; net_di = '0; #1;
    chk("in_full_ri2", {63'd0, net_ri}, 64'd0);
    rd(2'b00); chk("in_buf_kept", d_out, 64'h0000_0000_DEAD_BEEF);
    tick();  // consuming read of addr 00
    idle();
    chk("after_rd_ri", {63'd0, net_ri}, 64'd1);
    rd(2'b01); chk("after_rd_stat", d_out, 64'd0);
    rd(2'b00); chk("stale_in_buf", d_out, 64'h0000_0000_DEAD_BEEF);
    idle();

    // Output with VC=1; polarity 0 holds it back
    net_ro = 1'b1; net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_0055;
    tick();
    idle(); d_in = '0; #1;
    chk("vc_mismatch_so", {63'd0, net_so}, 64'd0);
    chk("out_do", net_do, 64'h8000_0000_0000_0055);
    rd(2'b11); chk("out_stat_full", d_out, 64'd1);
    rd(2'b10); chk("out_buf_rd", d_out, 64'h8000_0000_0000_0055);
    idle();
    net_polarity = 1'b1; #1;
    chk("vc_match_so", {63'd0, net_so}, 64'd1);
    chk("vc_match_do", net_do, 64'h8000_0000_0000_0055);
    tick();
    chk("sent_so", {63'd0, net_so}, 64'd0);
    rd(2'b11); chk("sent_stat", d_out, 64'd0);
    idle();

    // Router stalls; second write dropped
    net_ro = 1'b0; net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h7;
    tick();
    d_in = 64'h2;
    tick();
    idle(); d_in = '0; #1;
    chk("stall_so", {63'd0, net_so}, 64'd0);
    chk("drop_do", net_do, 64'h7);
    net_ro = 1'b1; #1;
    chk("release_so", {63'd0, net_so}, 64'd1);
    chk("release_do", net_do, 64'h7);
    tick();
    chk("release_done_so", {63'd0, net_so}, 64'd0);

    // Write to status address is ignored
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b11; d_in = 64'hFFFF;
    tick();
    rd(2'b11); chk("wr_stat_ignored", d_out, 64'd0);
    idle();

    // Fill both buffers, then reset
    net_ro = 1'b0;
    net_si = 1'b1; net_di = 64'hABCD;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h3;
    tick();
    net_si = 1'b0; idle();
    rd(2'b01); chk("pre_rst_in", d_out, 64'd1);
    rd(2'b11); chk("pre_rst_out", d_out, 64'd1);
    idle();
    net_ro = 1'b1; reset = 1'b1; #1;
    chk("rst_mid_so", {63'd0, net_so}, 64'd0);
    chk("rst_mid_ri", {63'd0, net_ri}, 64'd0);
    tick();
    reset = 1'b0; #1;
    chk("rst_done_so", {63'd0, net_so}, 64'd0);
    chk("rst_done_ri", {63'd0, net_ri}, 64'd1);
    rd(2'b01); chk("rst_done_in", d_out, 64'd0);
    rd(2'b11); chk("rst_done_out", d_out, 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
